mod_accum_bank: RTL and testbench

- Bank of CHANNELS independent modulo-MODULUS accumulators sharing one data input and one output.
- Increment and decrement requests are level inputs reduced internally to one-cycle pulses, so a held button or strobe counts once.
- Channel index `sel` selects the target of each operation and the value driven on `data_out`.
- Generalises the fixed two-channel, add-only, mod-10 accumulator to N channels, any modulus, subtract, clear and a wrap flag.

---
 rtl/mod_accum_bank.sv | 118 +++++++++++
 tb/tb_mod_accum_bank.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mod_accum_bank.sv
// mod_accum_bank: CHANNELS independent modulo-MODULUS accumulators sharing one
// operand input and one registered output, addressed by sel.
// add/sub are level inputs reduced to single pulses; clr is level-sensitive.
// Build option: define MOD_ACCUM_SATURATE_EN to clamp at 0 / MODULUS-1 instead
// of wrapping (wrap then flags overflow/underflow).
module mod_accum_bank #(
  parameter int  CHANNELS = 4,
  parameter int  DATA_W   = 4,
  parameter int  MODULUS  = 10,
  localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEL_W-1:0]  sel,
  input  logic              add,
  input  logic              sub,
  input  logic              clr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              wrap
);

  localparam logic [DATA_W:0]   MOD_X = (DATA_W+1)'(MODULUS);
  localparam logic [DATA_W-1:0] MAX_V = DATA_W'(MODULUS - 1);
  localparam logic [SEL_W:0]    CH_X  = (SEL_W+1)'(CHANNELS);

  logic [DATA_W-1:0] acc [CHANNELS];
  logic              add_q, sub_q, armed;
  logic              add_p, sub_p, sel_ok, acc_we, wrap_nxt;
  logic [DATA_W:0]   d, acc_x, sum;
  logic [DATA_W-1:0] acc_cur, acc_nxt;

  // Edge detection. The history registers reset low, so a request held high
  // across reset release would look like a fresh edge; armed masks pulses on
  // the first edge after reset so only a genuine low-to-high transition fires.
  always_comb begin
    add_p = add & ~add_q & armed;
    sub_p = sub & ~sub_q & armed;
  end

  // Select decode, operand folding and read of the selected channel.
  always_comb begin
    sel_ok  = ({1'b0, sel} < CH_X);
    d       = {1'b0, data_in} % MOD_X;
    acc_cur = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (sel == SEL_W'(i)) acc_cur = acc[i];
    end
    acc_x = {1'b0, acc_cur};
    sum   = acc_x + d;
  end

  // Next value of the selected channel, by operation priority.
  always_comb begin
    acc_nxt  = acc_cur;
    acc_we   = 1'b0;
    wrap_nxt = 1'b0;
    if (sel_ok) begin
      if (clr) begin
        acc_nxt = '0;
        acc_we  = 1'b1;
      end else if (add_p && sub_p) begin
        acc_we = 1'b0;
      end else if (add_p) begin
        acc_we = 1'b1;
        if (sum >= MOD_X) begin
          wrap_nxt = 1'b1;
`ifdef MOD_ACCUM_SATURATE_EN
          acc_nxt = MAX_V;
`else
          acc_nxt = DATA_W'(sum - MOD_X);
`endif
        end else begin
          acc_nxt = DATA_W'(sum);
        end
      end else if (sub_p) begin
        acc_we = 1'b1;
        if (acc_x < d) begin
          wrap_nxt = 1'b1;
`ifdef MOD_ACCUM_SATURATE_EN
          acc_nxt = '0;
`else
          acc_nxt = DATA_W'(acc_x + MOD_X - d);
`endif
        end else begin
          acc_nxt = DATA_W'(acc_x - d);
        end
      end
    end
  end

  // State: history, accumulators and the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_q    <= 1'b0;
      sub_q    <= 1'b0;
      armed    <= 1'b0;
      data_out <= '0;
      wrap     <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) acc[i] <= '0;
    end else begin
      add_q    <= add;
      sub_q    <= sub;
      armed    <= 1'b1;
      data_out <= sel_ok ? acc_nxt : '0;
      wrap     <= wrap_nxt;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (acc_we && sel == SEL_W'(i)) acc[i] <= acc_nxt;
      end
    end
  end

`ifndef MOD_ACCUM_SATURATE_EN
  logic [DATA_W-1:0] max_v_unused;
  assign max_v_unused = MAX_V;
`endif

endmodule

// File: tb/tb_mod_accum_bank.sv
// Bench for mod_accum_bank: directed scenarios plus random traffic, all
// checked against an integer model of the accumulator bank.
module tb_mod_accum_bank;
  localparam int CH  = 6;
  localparam int DW  = 4;
  localparam int MOD = 10;
  localparam int SW  = 3;
`ifdef MOD_ACCUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] sel;
  logic          add, sub, clr;
  logic [DW-1:0] data_in, data_out;
  logic          wrap;

  int checks = 0;
  int errors = 0;

  int model [CH];
  bit prev_add, prev_sub;
  int exp_out;
  bit exp_wrap;

  always #5 clk = ~clk;

  mod_accum_bank #(.CHANNELS(CH), .DATA_W(DW), .MODULUS(MOD)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .add(add), .sub(sub), .clr(clr),
    .data_in(data_in), .data_out(data_out), .wrap(wrap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // After reset a request only counts once it has been seen low.
  task automatic model_reset();
    for (int i = 0; i < CH; i++) model[i] = 0;
    prev_add = 1'b1;
    prev_sub = 1'b1;
    exp_out  = 0;
    exp_wrap = 1'b0;
  endtask

  // One clock edge of the bank, from the inputs currently applied.
  task automatic model_edge();
    bit ap, sp;
    int d, a;
    ap = add && !prev_add;
    sp = sub && !prev_sub;
    prev_add = add;
    prev_sub = sub;
    exp_wrap = 1'b0;
    if (int'(sel) >= CH) begin
      exp_out = 0;
      return;
    end
    d = int'(data_in) % MOD;
    a = model[sel];
    if (clr) a = 0;
    else if (ap && sp) a = a;
    else if (ap) begin
      if (a + d >= MOD) begin exp_wrap = 1'b1; a = SAT ? MOD - 1 : a + d - MOD; end
      else a = a + d;
    end else if (sp) begin
      if (a < d) begin exp_wrap = 1'b1; a = SAT ? 0 : a + MOD - d; end
      else a = a - d;
    end
    model[sel] = a;
    exp_out = a;
  endtask

  task automatic cycle(input string tag, input int s, input bit a, input bit b,
                       input bit c, input int din);
    sel = SW'(s); add = a; sub = b; clr = c; data_in = DW'(din);
    model_edge();
    @(posedge clk); #1;
    check({tag, ".out"}, 32'(data_out), 32'(exp_out));
    check({tag, ".wrap"}, 32'(wrap), 32'(exp_wrap));
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < (1 << SW); i++) cycle(tag, i, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    rst_n = 1'b0; sel = '0; add = 1'b0; sub = 1'b0; clr = 1'b0; data_in = '0;
    model_reset();
    #12;
    check("rst.out", 32'(data_out), 0);
    check("rst.wrap", 32'(wrap), 0);
    rst_n = 1'b1;
    cycle("idle", 0, 0, 0, 0, 0);
    read_all("rst.read");

    // Two add pulses of 7 on channel 0: 7, then 14 wraps to 4.
    cycle("add7a", 0, 1, 0, 0, 7);
    if (!SAT) check("add7a.const", 32'(data_out), 7);
    cycle("rel", 0, 0, 0, 0, 7);
    cycle("add7b", 0, 1, 0, 0, 7);
    if (!SAT) check("add7b.const", 32'(data_out), 4);
    cycle("wrap1cyc", 0, 0, 0, 0, 7);

    // Held add counts once.
    for (int k = 0; k < 5; k++) cycle("hold", 2, 1, 0, 0, 3);
    cycle("hold.rel", 2, 0, 0, 0, 3);
    check("hold.const", 32'(data_out), 3);
    read_all("hold.read");

    // Subtract below zero, then folded operand 13 -> 3.
    cycle("sub4", 1, 0, 1, 0, 4);
    if (!SAT) check("sub4.const", 32'(data_out), 6);
    cycle("rel", 1, 0, 0, 0, 0);
    cycle("add13", 1, 1, 0, 0, 13);
    if (!SAT) check("add13.const", 32'(data_out), 9);
    cycle("rel", 1, 0, 0, 0, 0);

    // add and sub rising together: no change.
    cycle("both", 0, 1, 1, 0, 5);
    cycle("rel", 0, 0, 0, 0, 0);

    // clr with an add edge: cleared, add discarded even if held.
    cycle("clradd", 0, 1, 0, 1, 5);
    check("clradd.const", 32'(data_out), 0);
    cycle("clradd.hold", 0, 1, 0, 0, 5);
    cycle("rel", 0, 0, 0, 0, 0);

    // Out-of-range select.
    cycle("oor", 6, 1, 0, 0, 5);
    check("oor.const", 32'(data_out), 0);
    cycle("rel", 7, 0, 0, 0, 0);
    read_all("oor.read");

    // Overflow/underflow boundaries on channel 3 (8+5, then 2-5).
    cycle("b.clr", 3, 0, 0, 1, 0);
    cycle("b.add8", 3, 1, 0, 0, 8);
    cycle("rel", 3, 0, 0, 0, 0);
    cycle("b.add5", 3, 1, 0, 0, 5);
    cycle("rel", 3, 0, 0, 0, 0);
    cycle("b.clr2", 3, 0, 0, 1, 0);
    cycle("b.add2", 3, 1, 0, 0, 2);
    cycle("rel", 3, 0, 0, 0, 0);
    cycle("b.sub5", 3, 0, 1, 0, 5);
    cycle("rel", 3, 0, 0, 0, 0);
    cycle("b.add15", 3, 1, 0, 0, 15);
    cycle("rel", 3, 0, 0, 0, 0);

    // Reset mid-sequence with add held high.
    cycle("pre", 0, 1, 0, 0, 3);
    cycle("pre", 0, 1, 0, 0, 3);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst.out", 32'(data_out), 0);
    check("midrst.wrap", 32'(wrap), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle("post.held", 0, 1, 0, 0, 3);
    cycle("post.held", 0, 1, 0, 0, 3);
    check("post.const", 32'(data_out), 0);
    cycle("post.low", 0, 0, 0, 0, 3);
    cycle("post.rise", 0, 1, 0, 0, 3);
    check("post.rise.const", 32'(data_out), 3);
    read_all("post.read");

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      cycle("rand", int'($urandom_range(0, 7)), bit'($urandom % 2), bit'($urandom % 2),
            ($urandom % 12) == 0, int'($urandom_range(0, 15)));
    end
    read_all("final.read");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
